// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: EX stage with forwarding, single-cycle ALU, iterative MULT/DIV unit and EX/MEM register
//   clk, rst_n                      clock, asynchronous active-low reset
//   flush_ex, valid_in              kill / qualify the instruction held in EX
//   data_1, data_2, imm             operands and immediate
//   rs, rt, rd, reg_dst             register indices and destination select
//   alu_ctrl, alu_src               operation and op_2 select
//   reg_write, mem_ctrl             writeback / memory controls carried to MEM
//   rd_wb, reg_write_wb,
//   write_data_wb                   WB forwarding source
//   stall_out                       holds IF/ID/EX while the MDU works
//   res_mem ... valid_mem           registered EX/MEM outputs
module ex_stage_mdu #(
  parameter int XLEN     = 32,
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_ex,
  input  logic            valid_in,
  input  logic [XLEN-1:0] data_1,
  input  logic [XLEN-1:0] data_2,
  input  logic [XLEN-1:0] imm,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      rd,
  input  logic [3:0]      alu_ctrl,
  input  logic            alu_src,
  input  logic            reg_dst,
  input  logic            reg_write,
  input  logic [2:0]      mem_ctrl,
  input  logic [4:0]      rd_wb,
  input  logic            reg_write_wb,
  input  logic [XLEN-1:0] write_data_wb,
  output logic            stall_out,
  output logic [XLEN-1:0] res_mem,
  output logic            zero_mem,
  output logic            over_mem,
  output logic [4:0]      write_register_mem,
  output logic [XLEN-1:0] write_data_mem,
  output logic [2:0]      mem_ctrl_mem,
  output logic            reg_write_mem,
  output logic            valid_mem
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic fin_q, fin_d;
  logic [XLEN-1:0] res_q, wdata_q;
  logic zero_q, over_q, reg_write_q, valid_q;
  logic [4:0] wreg_q;
  logic [2:0] mem_ctrl_q;
  logic [XLEN-1:0] hi_q, lo_q, acc_q, mq_q, b_q;
  logic div_q, lneg_q, hneg_q, dz_q;
  logic [XLEN-1:0] op_1, op_2, rt_val, sum, dif, alu_res;
  logic alu_ovf, is_mdu, start, bubble, vld;
  logic sgn, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, acc_d, mq_d, quo, rem, hi_d, lo_d;
  logic [XLEN:0] mul_s, div_t, div_r;
  logic [2*XLEN-1:0] prod;
  assign res_mem            = res_q;
  assign zero_mem           = zero_q;
  assign over_mem           = over_q;
  assign write_register_mem = wreg_q;
  assign write_data_mem     = wdata_q;
  assign mem_ctrl_mem       = mem_ctrl_q;
  assign reg_write_mem      = reg_write_q;
  assign valid_mem          = valid_q;
  always_comb begin
    op_1   = (reg_write_q && valid_q && wreg_q == rs && rs != 5'd0) ? res_q :
             (reg_write_wb && rd_wb == rs && rs != 5'd0) ? write_data_wb : data_1;
    rt_val = (reg_write_q && valid_q && wreg_q == rt && rt != 5'd0) ? res_q :
             (reg_write_wb && rd_wb == rt && rt != 5'd0) ? write_data_wb : data_2;
    op_2   = alu_src ? imm : rt_val;
  end
  assign sum = op_1 + op_2;
  assign dif = op_1 - op_2;
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_ctrl)
      4'd0: begin
        alu_res = sum;
        alu_ovf = (op_1[XLEN-1] == op_2[XLEN-1]) && (sum[XLEN-1] != op_1[XLEN-1]);
      end
      4'd1: begin
        alu_res = dif;
        alu_ovf = (op_1[XLEN-1] != op_2[XLEN-1]) && (dif[XLEN-1] != op_1[XLEN-1]);
      end
      4'd2:  alu_res = op_1 & op_2;
      4'd3:  alu_res = op_1 | op_2;
      4'd4:  alu_res = op_1 ^ op_2;
      4'd5:  alu_res = ~(op_1 | op_2);
      4'd6:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_1) < $signed(op_2)};
      4'd7:  alu_res = {{(XLEN-1){1'b0}}, op_1 < op_2};
      4'd8:  alu_res = op_2 << op_1[SW-1:0];
      4'd9:  alu_res = op_2 >> op_1[SW-1:0];
      4'd10: alu_res = $signed(op_2) >>> op_1[SW-1:0];
      4'd14: alu_res = hi_q;
      4'd15: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end
  // fin_q marks the cycle after DONE, when the held MDU op finally leaves EX instead of restarting
  assign is_mdu = alu_ctrl >= 4'd11 && alu_ctrl <= 4'd13;
  assign start  = state_q == IDLE && valid_in && is_mdu && !fin_q && !flush_ex;
  assign fin_d  = state_q == DONE && !flush_ex;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = BUSY;
        cnt_d   = CW'(XLEN);
      end
      BUSY: if (flush_ex) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    stall_out = rst_n && (state_q != IDLE || start);
  end
  // both multiply and divide run on magnitudes; signs are restored when HI/LO are written
  always_comb begin
    sgn   = alu_ctrl != 4'd12;
    a_neg = sgn && op_1[XLEN-1];
    b_neg = sgn && op_2[XLEN-1];
    a_mag = a_neg ? -op_1 : op_1;
    b_mag = b_neg ? -op_2 : op_2;
    mul_s = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_t = {acc_q, mq_q[XLEN-1]};
    div_r = div_t - {1'b0, b_q};
    acc_d = div_q ? (div_r[XLEN] ? div_t[XLEN-1:0] : div_r[XLEN-1:0]) : mul_s[XLEN:1];
    mq_d  = div_q ? {mq_q[XLEN-2:0], ~div_r[XLEN]} : {mul_s[0], mq_q[XLEN-1:1]};
    prod  = lneg_q ? -{acc_q, mq_q} : {acc_q, mq_q};
    quo   = lneg_q ? -mq_q : mq_q;
    rem   = hneg_q ? -acc_q : acc_q;
    hi_d  = div_q ? rem : prod[2*XLEN-1:XLEN];
    lo_d  = div_q ? (dz_q ? '1 : quo) : prod[XLEN-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      mq_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      lneg_q <= 1'b0;
      hneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      if (start) begin
        acc_q  <= '0;
        mq_q   <= a_mag;
        b_q    <= b_mag;
        div_q  <= alu_ctrl != 4'd11;
        lneg_q <= a_neg ^ b_neg;
        hneg_q <= a_neg;
        dz_q   <= op_2 == '0;
      end else if (state_q == BUSY) begin
        acc_q <= acc_d;
        mq_q  <= mq_d;
      end
      if (state_q == DONE) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end
  assign bubble = stall_out || flush_ex;
  assign vld    = valid_in && !bubble;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q       <= '0;
      zero_q      <= 1'b0;
      over_q      <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      mem_ctrl_q  <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      res_q       <= alu_res;
      zero_q      <= alu_res == '0;
      over_q      <= alu_ovf;
      wreg_q      <= reg_dst ? rd : rt;
      wdata_q     <= rt_val;
      mem_ctrl_q  <= vld ? mem_ctrl : 3'd0;
      reg_write_q <= vld && reg_write && !is_mdu && !(OVF_TRAP && alu_ovf);
      valid_q     <= vld;
    end
  end
endmodule

// File: tb/tb_ex_stage_mdu.sv
// tb_ex_stage_mdu: directed checks of ALU, forwarding, overflow trap, MDU timing/results, flush and async reset
module tb_ex_stage_mdu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_ex = 1'b0, valid_in = 1'b0;
  logic [31:0] data_1 = '0, data_2 = '0, imm = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0;
  logic [3:0] alu_ctrl = '0;
  logic alu_src = 1'b0, reg_dst = 1'b0, reg_write = 1'b0;
  logic [2:0] mem_ctrl = '0;
  logic [4:0] rd_wb = '0;
  logic reg_write_wb = 1'b0;
  logic [31:0] write_data_wb = '0;
  logic stall_out, zero_mem, over_mem, reg_write_mem, valid_mem;
  logic [31:0] res_mem, write_data_mem;
  logic [4:0] write_register_mem;
  logic [2:0] mem_ctrl_mem;
  int checks = 0, errors = 0;
  int n;
  logic [31:0] r;
  ex_stage_mdu #(.XLEN(32), .OVF_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush_ex(flush_ex), .valid_in(valid_in),
    .data_1(data_1), .data_2(data_2), .imm(imm), .rs(rs), .rt(rt), .rd(rd),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_ctrl(mem_ctrl), .rd_wb(rd_wb), .reg_write_wb(reg_write_wb),
    .write_data_wb(write_data_wb), .stall_out(stall_out), .res_mem(res_mem),
    .zero_mem(zero_mem), .over_mem(over_mem), .write_register_mem(write_register_mem),
    .write_data_mem(write_data_mem), .mem_ctrl_mem(mem_ctrl_mem),
    .reg_write_mem(reg_write_mem), .valid_mem(valid_mem)
  );
  always #5 clk = ~clk;
  logic [3:0]  t_op  [9] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd1};
  logic [31:0] t_a   [9] = '{32'hF0F0, 32'hFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h8, 32'h4, 32'h4, 32'h80000000};
  logic [31:0] t_b   [9] = '{32'hFF00, 32'h0F, 32'h0, 32'h1, 32'h1, 32'h1, 32'h80000000, 32'h80000000, 32'h1};
  logic [31:0] t_exp [9] = '{32'hF000, 32'hF0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h100, 32'h08000000, 32'hF8000000, 32'h7FFFFFFF};
  logic        t_ovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        t_zero[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    valid_in = 1'b1;
    alu_ctrl = op;
    data_1 = a;
    data_2 = b;
    rs = s;
    rt = t;
    rd = d;
    reg_dst = 1'b1;
    reg_write = 1'b1;
    alu_src = 1'b0;
    imm = '0;
    mem_ctrl = '0;
  endtask
  task automatic run_mdu(output int cnt);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_out) break;
      cnt++;
    end
  endtask
  task automatic mf(input logic [3:0] op, output logic [31:0] v);
    setop(op, 32'h0, 32'h0, 5'd0, 5'd0, 5'd1);
    step();
    v = res_mem;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #3;
    check("rst_res", res_mem, 0);
    check("rst_valid", valid_mem, 0);
    check("rst_regwr", reg_write_mem, 0);
    check("rst_stall", stall_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    setop(4'd0, 32'h7FFFFFFF, 32'h1, 5'd1, 5'd2, 5'd3);
    step();
    check("add_ovf_res", res_mem, 32'h80000000);
    check("add_ovf_over", over_mem, 1);
    check("add_ovf_regwr", reg_write_mem, 0);
    check("add_ovf_valid", valid_mem, 1);
    setop(4'd0, 32'd10, 32'd20, 5'd1, 5'd2, 5'd5);
    step();
    check("add_r5_res", res_mem, 30);
    check("add_r5_regwr", reg_write_mem, 1);
    setop(4'd1, 32'd999, 32'd4, 5'd5, 5'd2, 5'd7);
    rd_wb = 5'd5;
    reg_write_wb = 1'b1;
    write_data_wb = 32'd9;
    step();
    check("fwd_mem_prio", res_mem, 26);
    check("fwd_mem_wreg", write_register_mem, 7);
    check("fwd_mem_wdata", write_data_mem, 4);
    setop(4'd1, 32'd999, 32'd999, 5'd5, 5'd7, 5'd8);
    step();
    check("fwd_wb_rs_mem_rt", res_mem, 32'hFFFFFFEF);
    check("fwd_rt_wdata", write_data_mem, 26);
    reg_write_wb = 1'b0;
    for (int i = 0; i < 9; i++) begin
      setop(t_op[i], t_a[i], t_b[i], 5'd0, 5'd0, 5'd4);
      step();
      check($sformatf("alu%0d_res", i), res_mem, t_exp[i]);
      check($sformatf("alu%0d_over", i), over_mem, t_ovf[i]);
      check($sformatf("alu%0d_zero", i), zero_mem, t_zero[i]);
    end
    setop(4'd0, 32'd5, 32'd100, 5'd0, 5'd9, 5'd4);
    alu_src = 1'b1;
    imm = 32'hFFFFFFFF;
    reg_dst = 1'b0;
    mem_ctrl = 3'd5;
    step();
    check("imm_res", res_mem, 4);
    check("imm_wreg_rt", write_register_mem, 9);
    check("imm_wdata", write_data_mem, 100);
    check("imm_memctrl", mem_ctrl_mem, 5);
    setop(4'd11, 32'hFFFFFFFD, 32'd7, 5'd0, 5'd0, 5'd1);
    run_mdu(n);
    check("mult_stall_cycles", n, 34);
    step();
    check("mult_leave_valid", valid_mem, 1);
    check("mult_leave_regwr", reg_write_mem, 0);
    mf(4'd15, r);
    check("mult_lo", r, 32'hFFFFFFEB);
    mf(4'd14, r);
    check("mult_hi", r, 32'hFFFFFFFF);
    setop(4'd13, 32'hFFFFFFF9, 32'd2, 5'd0, 5'd0, 5'd1);
    run_mdu(n);
    check("div_stall_cycles", n, 34);
    step();
    mf(4'd15, r);
    check("div_lo", r, 32'hFFFFFFFD);
    mf(4'd14, r);
    check("div_hi", r, 32'hFFFFFFFF);
    setop(4'd12, 32'd5, 32'd0, 5'd0, 5'd0, 5'd1);
    run_mdu(n);
    check("divu0_stall_cycles", n, 34);
    step();
    mf(4'd15, r);
    check("divu0_lo", r, 32'hFFFFFFFF);
    mf(4'd14, r);
    check("divu0_hi", r, 5);
    setop(4'd13, 32'd100, 32'd7, 5'd0, 5'd0, 5'd1);
    @(negedge clk);
    check("flush_issue_stall", stall_out, 1);
    repeat (10) @(negedge clk);
    flush_ex = 1'b1;
    #1;
    check("flush_cycle_stall", stall_out, 1);
    step();
    flush_ex = 1'b0;
    valid_in = 1'b0;
    check("flush_bubble_valid", valid_mem, 0);
    @(negedge clk);
    check("flush_stall_drop", stall_out, 0);
    step();
    mf(4'd15, r);
    check("flush_lo_kept", r, 32'hFFFFFFFF);
    mf(4'd14, r);
    check("flush_hi_kept", r, 5);
    setop(4'd11, 32'hFFFFFFFD, 32'd7, 5'd0, 5'd0, 5'd1);
    repeat (5) @(negedge clk);
    #2;
    check("pre_rst_stall", stall_out, 1);
    check("pre_rst_wdata", write_data_mem, 7);
    rst_n = 1'b0;
    #1;
    check("arst_stall", stall_out, 0);
    check("arst_wdata", write_data_mem, 0);
    check("arst_valid", valid_mem, 0);
    check("arst_zero", zero_mem, 0);
    valid_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    mf(4'd15, r);
    check("arst_lo", r, 0);
    mf(4'd14, r);
    check("arst_hi", r, 0);
    valid_in = 1'b0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
